instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/fetch_pkg.sv | 14 +
 rtl/instr_fetch_unit.sv | 103 ++++++++++
 tb/tb_instr_fetch_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds the fetch FSM state encoding, the sequential PC increment and the word-alignment mask.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam int PC_STEP    = 4;
    localparam int ALIGN_MASK = 3;

endpackage

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetcher: one request, one held word, at most one instr per 2 cycles.
// Ack-to-instr_valid latency is 1 cycle; instr holds until decode asserts instr_ready.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int Data_Width = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [Data_Width-1:0] PC,
    output logic [Data_Width-1:0] PC_Instr,
    input  logic                  redirect,
    input  logic [Data_Width-1:0] redirect_pc,
    output logic                  imem_req,
    output logic [Data_Width-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [Data_Width-1:0] imem_rdata,
    output logic [Data_Width-1:0] instr,
    output logic                  instr_valid,
    input  logic                  instr_ready
);

    fetch_state_e          state_q, state_d;
    logic [Data_Width-1:0] addr_q, addr_d;
    logic [Data_Width-1:0] instr_q, instr_d;
    logic                  valid_q, valid_d;
    logic                  flush_q, flush_d;
    logic [Data_Width-1:0] pc_next;
    logic [Data_Width-1:0] redirect_tgt;
    logic [Data_Width-1:0] pc_plus_step;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        pc_plus_step = PC + Data_Width'(PC_STEP);
        redirect_tgt = redirect_pc & ~Data_Width'(ALIGN_MASK);
        state_d      = state_q;
        addr_d       = addr_q;
        instr_d      = instr_q;
        valid_d      = valid_q;
        flush_d      = flush_q;

        pc_next = PC;
        if (redirect) begin
            pc_next = redirect_tgt;
        end else if (state_q == HOLD && instr_ready) begin
            pc_next = pc_plus_step;
        end

        case (state_q)
            IDLE: begin
                state_d = REQ;
                addr_d  = pc_next;
                valid_d = 1'b0;
            end
            REQ: begin
                if (imem_ack) begin
                    // A redirect seen before or with the ack makes this word stale.
                    if (flush_q || redirect) begin
                        flush_d = 1'b0;
                        addr_d  = pc_next;
                    end else begin
                        instr_d = imem_rdata;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end else if (redirect) begin
                    flush_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect || instr_ready) begin
                    valid_d = 1'b0;
                    state_d = REQ;
                    addr_d  = pc_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The program counter must not follow a redirect while the unit is held in reset.
    assign PC_Instr    = reset ? pc_next : PC;
    assign imem_req    = (state_q == REQ);
    assign imem_addr   = addr_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, reset corner cases, then random traffic vs a model.
module tb_instr_fetch_unit;

    localparam int W = 32;

    typedef struct {
        logic         redir;
        logic [W-1:0] rpc;
        logic         ack;
        logic [W-1:0] rdata;
        logic         ready;
        logic         x_req;
        logic [W-1:0] x_addr;
        logic         x_vld;
        logic [W-1:0] x_instr;
        logic [W-1:0] x_pci;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] PC;
    logic [W-1:0] PC_Instr;
    logic         redirect;
    logic [W-1:0] redirect_pc;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         imem_ack;
    logic [W-1:0] imem_rdata;
    logic [W-1:0] instr;
    logic         instr_valid;
    logic         instr_ready;

    int total = 0;
    int bad   = 0;

    instr_fetch_unit #(.Data_Width(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .PC         (PC),
        .PC_Instr   (PC_Instr),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [W-1:0] rpc, input logic a,
                                input logic [W-1:0] rd, input logic rdy, input logic xr,
                                input logic [W-1:0] xa, input logic xv, input logic [W-1:0] xi,
                                input logic [W-1:0] xp);
        vec_t v;
        v.redir = r;   v.rpc = rpc;  v.ack = a;     v.rdata = rd;   v.ready = rdy;
        v.x_req = xr;  v.x_addr = xa; v.x_vld = xv; v.x_instr = xi; v.x_pci = xp;
        return v;
    endfunction

    // Entered at posedge+1; PC afterwards takes the value the program counter would load.
    task automatic run_vec(input vec_t v, input int idx);
        redirect    = v.redir;
        redirect_pc = v.rpc;
        imem_ack    = v.ack;
        imem_rdata  = v.rdata;
        instr_ready = v.ready;
        @(negedge clk);
        chk($sformatf("v%0d pc_instr", idx), PC_Instr, v.x_pci);
        chk($sformatf("v%0d imem_req", idx), W'(imem_req), W'(v.x_req));
        if (v.x_req) chk($sformatf("v%0d imem_addr", idx), imem_addr, v.x_addr);
        chk($sformatf("v%0d instr_valid", idx), W'(instr_valid), W'(v.x_vld));
        if (v.x_vld) chk($sformatf("v%0d instr", idx), instr, v.x_instr);
        @(posedge clk);
        #1;
        PC = v.x_pci;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl[$];
        bit           m_boot, m_wait, m_drop, m_have;
        logic [W-1:0] m_addr, m_word, exp_pci;
        logic         r, a, rdy;
        logic [W-1:0] rpc, rd;

        reset = 1'b0; PC = 32'h40; redirect = 1'b1; redirect_pc = 32'h123;
        imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst pc_instr", PC_Instr, 32'h40);
        chk("rst imem_req", W'(imem_req), '0);
        chk("rst instr_valid", W'(instr_valid), '0);
        chk("rst instr", instr, '0);
        chk("rst imem_addr", imem_addr, '0);
        @(posedge clk); #1;
        redirect = 1'b0; PC = '0; reset = 1'b1;

        // Fetch from 0, 5-cycle decode stall, step, redirect in HOLD, same-cycle redirect+ack, wrap.
        tbl.push_back(mk(0, 0, 0, 0, 0,             0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,             1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'h11111111, 0,  1, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 0, 0, 0, 0,         0, 0, 1, 32'h11111111, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1,             0, 0, 1, 32'h11111111, 4));
        tbl.push_back(mk(0, 0, 0, 0, 0,             1, 4, 0, 0, 4));
        tbl.push_back(mk(0, 0, 1, 32'h22222222, 0,  1, 4, 0, 0, 4));
        tbl.push_back(mk(1, 32'h00400023, 0, 0, 1,  0, 0, 1, 32'h22222222, 32'h00400020));
        tbl.push_back(mk(0, 0, 0, 0, 0,             1, 32'h00400020, 0, 0, 32'h00400020));
        tbl.push_back(mk(1, 32'hFFFFFFFF, 1, 32'h33333333, 0, 1, 32'h00400020, 0, 0, 32'hFFFFFFFC));
        tbl.push_back(mk(0, 0, 1, 32'h44444444, 0,  1, 32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC));
        tbl.push_back(mk(0, 0, 0, 0, 1,             0, 0, 1, 32'h44444444, 32'h00000000));
        tbl.push_back(mk(0, 0, 0, 0, 0,             1, 0, 0, 0, 0));
        // Redirect in REQ, ack three cycles later is dropped, then the target is fetched.
        tbl.push_back(mk(1, 32'h1000, 0, 0, 0,      1, 0, 0, 0, 32'h1000));
        tbl.push_back(mk(0, 0, 0, 0, 0,             1, 0, 0, 0, 32'h1000));
        tbl.push_back(mk(0, 0, 0, 0, 0,             1, 0, 0, 0, 32'h1000));
        tbl.push_back(mk(0, 0, 1, 32'hDEAD, 0,      1, 0, 0, 0, 32'h1000));
        tbl.push_back(mk(0, 0, 0, 0, 0,             1, 32'h1000, 0, 0, 32'h1000));
        tbl.push_back(mk(0, 0, 1, 32'h5555, 0,      1, 32'h1000, 0, 0, 32'h1000));
        tbl.push_back(mk(0, 0, 0, 0, 1,             0, 0, 1, 32'h5555, 32'h1004));
        // After a reset mid-request: a stale ack in IDLE must not produce an instruction.
        tbl.push_back(mk(0, 0, 1, 32'hBAD, 0,       0, 0, 0, 0, 32'h2000));
        tbl.push_back(mk(0, 0, 0, 0, 0,             1, 32'h2000, 0, 0, 32'h2000));
        tbl.push_back(mk(0, 0, 0, 0, 0,             1, 32'h2000, 0, 0, 32'h2000));

        for (int i = 0; i < 24; i++) run_vec(tbl[i], i);

        redirect = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
        #1;
        chk("midreq imem_req", W'(imem_req), 1);
        chk("midreq imem_addr", imem_addr, 32'h1004);
        reset = 1'b0;
        #1;
        chk("arst imem_req", W'(imem_req), '0);
        chk("arst instr_valid", W'(instr_valid), '0);
        chk("arst imem_addr", imem_addr, '0);
        chk("arst pc_instr", PC_Instr, 32'h1004);
        @(posedge clk); #1;
        reset = 1'b1; PC = 32'h2000;
        for (int i = 24; i < tbl.size(); i++) run_vec(tbl[i], i);

        // Random traffic against a transaction-level model of the fetcher.
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; PC = 32'hFFFFFFF0;
        m_boot = 1; m_wait = 0; m_drop = 0; m_have = 0; m_addr = '0; m_word = '0;
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | W'($urandom_range(0, 15))) : W'($urandom());
            a   = m_wait ? ($urandom_range(0, 2) == 0) : (m_boot ? 1'($urandom_range(0, 1)) : 1'b0);
            rd  = W'($urandom());
            rdy = 1'($urandom_range(0, 1));
            if (r)                exp_pci = {rpc[W-1:2], 2'b00};
            else if (m_have && rdy) exp_pci = PC + 32'd4;
            else                  exp_pci = PC;
            redirect = r; redirect_pc = rpc; imem_ack = a; imem_rdata = rd; instr_ready = rdy;
            @(negedge clk);
            chk($sformatf("r%0d pc_instr", i), PC_Instr, exp_pci);
            chk($sformatf("r%0d imem_req", i), W'(imem_req), W'(m_wait));
            if (m_wait) chk($sformatf("r%0d imem_addr", i), imem_addr, m_addr);
            chk($sformatf("r%0d instr_valid", i), W'(instr_valid), W'(m_have));
            if (m_have) chk($sformatf("r%0d instr", i), instr, m_word);
            @(posedge clk); #1;
            if (m_boot) begin
                m_boot = 0; m_wait = 1; m_addr = exp_pci;
            end else if (m_wait) begin
                if (a && (m_drop || r)) begin
                    m_drop = 0; m_addr = exp_pci;
                end else if (a) begin
                    m_wait = 0; m_have = 1; m_word = rd;
                end else if (r) begin
                    m_drop = 1;
                end
            end else if (m_have && (r || rdy)) begin
                m_have = 0; m_wait = 1; m_addr = exp_pci;
            end
            PC = exp_pci;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
